// File: rtl/mux4_arbiter.sv
// Rotating-priority 4:1 grant arbiter driving the select of a shared Mux4.
// Optional hold limit: define MUX4_ARBITER_TIMEOUT_EN to force-release after MAX_HOLD cycles.
module mux4_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD out of range 2..255");
    end

`ifdef MUX4_ARBITER_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold;
`else
    assign timeout = 1'b0;
`endif

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'b00;
            busy  <= 1'b0;
            ptr   <= 2'b00;
`ifdef MUX4_ARBITER_TIMEOUT_EN
            hold    <= 8'd0;
            timeout <= 1'b0;
`endif
        end else begin
`ifdef MUX4_ARBITER_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << win;
                        sel   <= win;
                        busy  <= 1'b1;
                        ptr   <= win + 2'd1;
`ifdef MUX4_ARBITER_TIMEOUT_EN
                        hold  <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (done || !req[sel]) begin
                        state <= IDLE;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                    end
`ifdef MUX4_ARBITER_TIMEOUT_EN
                    else if (hold == HOLD_LAST) begin
                        state   <= IDLE;
                        gnt     <= 4'b0000;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        hold <= hold + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
